// File: rtl/mc_req_sequencer.sv
// Host request front end for the memory controller port.
// Ports: host req/rsp handshakes in, mc_* controller strobes out.
module mc_req_sequencer #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 8,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mc_addr,
    output logic              mc_wr_en,
    output logic              mc_rd_en,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic [DATA_W-1:0] mc_rdata
);

    localparam int CA = $clog2(CMD_DEPTH);
    localparam int RA = $clog2(RSP_DEPTH);
    localparam int CW = RA + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);

    logic              cmd_wr_q   [CMD_DEPTH];
    logic [ADDR_W-1:0] cmd_addr_q [CMD_DEPTH];
    logic [DATA_W-1:0] cmd_data_q [CMD_DEPTH];
    logic [DATA_W-1:0] rsp_mem    [RSP_DEPTH];

    logic [CA:0]       cmd_wptr, cmd_rptr;
    logic [RA:0]       rsp_wptr, rsp_rptr;
    logic [CW-1:0]     credits;
    logic [RD_LAT-1:0] rd_pipe;
    logic [RD_LAT:0]   pipe_ext;
    logic              ready_en;

    logic              cmd_empty, cmd_full, push;
    logic              head_wr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              issue, rd_issue, wr_issue;
    logic              rsp_empty, rsp_push, rsp_pop;

    assign cmd_empty = (cmd_wptr == cmd_rptr);
    assign cmd_full  = (cmd_wptr[CA] != cmd_rptr[CA]) &&
                       (cmd_wptr[CA-1:0] == cmd_rptr[CA-1:0]);

    // ready_en keeps req_ready low until the first edge after reset release
    assign req_ready = ready_en && !cmd_full;
    assign push      = req_valid && req_ready;

    assign head_wr   = cmd_wr_q[cmd_rptr[CA-1:0]];
    assign head_addr = cmd_addr_q[cmd_rptr[CA-1:0]];
    assign head_data = cmd_data_q[cmd_rptr[CA-1:0]];

    // a credit-starved read at the head stalls everything behind it
    assign issue    = !cmd_empty && (head_wr || (credits != '0));
    assign rd_issue = issue && !head_wr;
    assign wr_issue = issue && head_wr;

    assign rsp_empty = (rsp_wptr == rsp_rptr);
    assign rsp_valid = !rsp_empty;
    assign rsp_data  = rsp_empty ? '0 : rsp_mem[rsp_rptr[RA-1:0]];
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_push  = rd_pipe[RD_LAT-1];

    assign pipe_ext = {rd_pipe, mc_rd_en};

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_wr_q[cmd_wptr[CA-1:0]]   <= req_wr;
            cmd_addr_q[cmd_wptr[CA-1:0]] <= req_addr;
            cmd_data_q[cmd_wptr[CA-1:0]] <= req_wdata;
        end
        if (rsp_push) begin
            rsp_mem[rsp_wptr[RA-1:0]] <= mc_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
            cmd_wptr <= '0;
            cmd_rptr <= '0;
            rsp_wptr <= '0;
            rsp_rptr <= '0;
            credits  <= CRED_MAX;
            rd_pipe  <= '0;
            mc_addr  <= '0;
            mc_wr_en <= 1'b0;
            mc_rd_en <= 1'b0;
            mc_wdata <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) cmd_wptr <= cmd_wptr + (CA+1)'(1);
            if (issue) cmd_rptr <= cmd_rptr + (CA+1)'(1);
            if (rsp_push) rsp_wptr <= rsp_wptr + (RA+1)'(1);
            if (rsp_pop) rsp_rptr <= rsp_rptr + (RA+1)'(1);
            unique case (1'b1)
                rd_issue && !rsp_pop: credits <= credits - CW'(1);
                !rd_issue && rsp_pop: credits <= credits + CW'(1);
                default: ;
            endcase
            // shift in the read strobe as the controller samples it
            rd_pipe  <= pipe_ext[RD_LAT-1:0];
            mc_wr_en <= wr_issue;
            mc_rd_en <= rd_issue;
            mc_addr  <= issue ? head_addr : '0;
            mc_wdata <= wr_issue ? head_data : '0;
        end
    end

endmodule

// File: tb/tb_mc_req_sequencer.sv
// Directed bench for mc_req_sequencer with a RD_LAT=1 controller model.
// Checks via immediate assertions; summary line at end.
module tb_mc_req_sequencer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] mc_addr;
    logic       mc_wr_en;
    logic       mc_rd_en;
    logic [7:0] mc_wdata;
    logic [7:0] mc_rdata;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rd0, wr0;

    logic [7:0] mem [4];

    mc_req_sequencer dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .mc_addr(mc_addr),
        .mc_wr_en(mc_wr_en),
        .mc_rd_en(mc_rd_en),
        .mc_wdata(mc_wdata),
        .mc_rdata(mc_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // controller model: one-cycle registered read, write-first memory
    always @(posedge clk) begin
        if (mc_wr_en) mem[mc_addr] <= mc_wdata;
        if (mc_rd_en) mc_rdata <= mem[mc_addr];
        if (mc_rd_en) rd_cnt <= rd_cnt + 1;
        if (mc_wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [1:0] a,
                        input logic [7:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_accept", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, {31'b0, rsp_valid}, 32'd1);
        chk(tag, {24'b0, rsp_data}, {24'b0, exp});
        tick();
    endtask

    task automatic idle_mc(input string tag);
        chk(tag, {20'b0, mc_wr_en, mc_rd_en, mc_addr, mc_wdata}, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp", {23'b0, rsp_valid, rsp_data}, 32'd0);
        idle_mc("rst_mc");
        tick();
        tick();
        reset = 1'b1;
        chk("rel_ready0", {31'b0, req_ready}, 32'd0);
        tick();
        chk("rel_ready1", {31'b0, req_ready}, 32'd1);

        // single write
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 2'd2; req_wdata = 8'hA5;
        tick();
        req_valid = 1'b0;
        chk("w1_nobypass", {31'b0, mc_wr_en}, 32'd0);
        tick();
        chk("w1_issue", {20'b0, mc_wr_en, mc_rd_en, mc_addr, mc_wdata},
            {20'b0, 1'b1, 1'b0, 2'd2, 8'hA5});
        tick();
        idle_mc("w1_done");
        chk("w1_norsp", {31'b0, rsp_valid}, 32'd0);

        // write then read same address
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 2'd1; req_wdata = 8'h3C;
        tick();
        req_wr = 1'b0; req_wdata = 8'h00;
        tick();
        req_valid = 1'b0;
        chk("wr_rd_w", {20'b0, mc_wr_en, mc_rd_en, mc_addr, mc_wdata},
            {20'b0, 1'b1, 1'b0, 2'd1, 8'h3C});
        tick();
        chk("wr_rd_r", {20'b0, mc_wr_en, mc_rd_en, mc_addr, mc_wdata},
            {20'b0, 1'b0, 1'b1, 2'd1, 8'h00});
        tick();
        chk("wr_rd_wait", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("wr_rd_rsp", {23'b0, rsp_valid, rsp_data}, {23'b0, 1'b1, 8'h3C});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_rd_pop", {31'b0, rsp_valid}, 32'd0);

        // preload controller memory
        send(1'b1, 2'd0, 8'h11);
        send(1'b1, 2'd1, 8'h22);
        send(1'b1, 2'd2, 8'h33);
        send(1'b1, 2'd3, 8'h44);
        repeat (4) tick();

        // six reads against four credits
        rd0 = rd_cnt;
        send(1'b0, 2'd0, 8'h00);
        send(1'b0, 2'd1, 8'h00);
        send(1'b0, 2'd2, 8'h00);
        send(1'b0, 2'd3, 8'h00);
        send(1'b0, 2'd1, 8'h00);
        send(1'b0, 2'd2, 8'h00);
        repeat (6) tick();
        chk("cred_rd4", rd_cnt - rd0, 32'd4);
        chk("cred_head", {23'b0, rsp_valid, rsp_data}, {23'b0, 1'b1, 8'h11});
        rsp_ready = 1'b1;
        take("r6_0", 8'h11);
        take("r6_1", 8'h22);
        take("r6_2", 8'h33);
        take("r6_3", 8'h44);
        take("r6_4", 8'h22);
        take("r6_5", 8'h33);
        rsp_ready = 1'b0;
        chk("cred_rd6", rd_cnt - rd0, 32'd6);

        // starve credits, then block a read with writes queued behind
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        send(1'b0, 2'd0, 8'h00);
        send(1'b0, 2'd1, 8'h00);
        send(1'b0, 2'd2, 8'h00);
        send(1'b0, 2'd3, 8'h00);
        send(1'b0, 2'd1, 8'h00);
        send(1'b1, 2'd0, 8'h55);
        send(1'b1, 2'd3, 8'h66);
        send(1'b0, 2'd3, 8'h00);
        chk("full_ready", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 2'd2; req_wdata = 8'h77;
        repeat (3) tick();
        req_valid = 1'b0;
        chk("full_hold", {31'b0, req_ready}, 32'd0);
        chk("blk_rd4", rd_cnt - rd0, 32'd4);
        chk("blk_nowr", wr_cnt - wr0, 32'd0);
        idle_mc("blk_idle");

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("pop_still_full", {31'b0, req_ready}, 32'd0);
        idle_mc("pop_noissue");
        tick();
        chk("unblk_rd", {20'b0, mc_wr_en, mc_rd_en, mc_addr, mc_wdata},
            {20'b0, 1'b0, 1'b1, 2'd1, 8'h00});
        chk("unblk_ready", {31'b0, req_ready}, 32'd1);
        tick();
        chk("unblk_w1", {20'b0, mc_wr_en, mc_rd_en, mc_addr, mc_wdata},
            {20'b0, 1'b1, 1'b0, 2'd0, 8'h55});
        tick();
        chk("unblk_w2", {20'b0, mc_wr_en, mc_rd_en, mc_addr, mc_wdata},
            {20'b0, 1'b1, 1'b0, 2'd3, 8'h66});
        tick();
        idle_mc("reblock");
        rsp_ready = 1'b1;
        take("d_0", 8'h22);
        take("d_1", 8'h33);
        take("d_2", 8'h44);
        take("d_3", 8'h22);
        take("d_4", 8'h66);
        rsp_ready = 1'b0;
        chk("wr_no_extra", wr_cnt - wr0, 32'd2);

        // reset with reads in flight and one response queued
        send(1'b0, 2'd0, 8'h00);
        send(1'b0, 2'd1, 8'h00);
        send(1'b0, 2'd2, 8'h00);
        tick();
        chk("pre_rst_rsp", {31'b0, rsp_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_rsp", {23'b0, rsp_valid, rsp_data}, 32'd0);
        idle_mc("mid_rst_mc");
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("post_rst_norsp", {31'b0, rsp_valid}, 32'd0);
        rd0 = rd_cnt;
        send(1'b0, 2'd0, 8'h00);
        send(1'b0, 2'd1, 8'h00);
        send(1'b0, 2'd2, 8'h00);
        send(1'b0, 2'd3, 8'h00);
        repeat (6) tick();
        chk("post_rst_rd4", rd_cnt - rd0, 32'd4);
        rsp_ready = 1'b1;
        take("p_0", 8'h55);
        take("p_1", 8'h22);
        take("p_2", 8'h33);
        take("p_3", 8'h66);
        rsp_ready = 1'b0;
        tick();
        chk("p_empty", {31'b0, rsp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_req_sequencer.md
Name: mc_req_sequencer

Overview:
- Host-side request front end that sits directly upstream of the memory controller and drives its port: addr, wr_en, rd_en, wdata, with rdata returned.
- Accepts read/write commands on a valid/ready handshake and buffers them in an in-order command FIFO.
- Issues at most one command per cycle to the controller.
- Captures read data after a fixed latency into a response FIFO that has its own valid/ready handshake.
- Read issue is credit-limited, so returned data can never overflow the response FIFO.

Parameters:
- ADDR_W, 2, controller address width
- DATA_W, 8, data width
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
- RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
- RD_LAT, 1, cycles from controller sampling rd_en to rdata valid (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  host command valid
- req_ready  out  1  command FIFO can accept
- req_wr  in  1  1=write, 0=read
- req_addr  in  ADDR_W  command address
- req_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read response available
- rsp_ready  in  1  host accepts response
- rsp_data  out  DATA_W  read data, head of response FIFO
- mc_addr  out  ADDR_W  to controller addr
- mc_wr_en  out  1  to controller wr_en
- mc_rd_en  out  1  to controller rd_en
- mc_wdata  out  DATA_W  to controller wdata
- mc_rdata  in  DATA_W  from controller rdata

Behaviour:
- Reset (reset=0, async) values:
  - req_ready=0 while reset is asserted; req_ready=1 from the first edge after release.
  - rsp_valid=0, rsp_data=0.
  - mc_addr=0, mc_wr_en=0, mc_rd_en=0, mc_wdata=0.
  - Both FIFOs empty; credits=RSP_DEPTH; read-latency pipeline cleared.
  - Asserting reset mid-operation discards all queued commands and in-flight reads. No stale response appears after release.
- Command accept:
  - A command is pushed on the edge where req_valid&&req_ready.
  - req_ready = !cmd_full. No pass-through: a push into a full FIFO is not allowed even if a pop happens in the same cycle.
- Issue:
  - Issue condition: at an edge, FIFO non-empty and (head is a write, or credits>0).
  - On issue, pop the head and register the mc_* outputs for exactly one cycle: mc_wr_en or mc_rd_en =1, plus mc_addr and mc_wdata (mc_wdata=0 for reads).
  - In cycles with no issue, all mc_* outputs =0.
  - mc_wr_en and mc_rd_en are never both 1.
- Ordering:
  - Strictly in order. A read blocked on credits also blocks every later write, so there is no reordering and no read-after-write hazard.
- Latency:
  - Command accepted at edge t into an empty FIFO: mc_*_en is high between edges t+1 and t+2, and the controller samples it at t+2.
  - A command can never issue in the same edge it is pushed.
- Read return:
  - A RD_LAT-deep valid shift register tracks each read.
  - mc_rdata is captured into the response FIFO at edge t+2+RD_LAT. rsp_valid is 1 after that edge.
- Credits:
  - Decrement by 1 when a read issues.
  - Increment by 1 on a response pop (rsp_valid&&rsp_ready).
  - A simultaneous issue and pop leaves credits unchanged.
  - Invariant: in-flight reads + response FIFO occupancy + credits = RSP_DEPTH. The response FIFO never overflows.
- Response FIFO:
  - rsp_valid = !rsp_empty; rsp_data = head entry, 0 when empty.
  - A push and pop in the same cycle are both honoured.
  - Response data is held stable while rsp_valid&&!rsp_ready.
- Pointers: FIFO pointers wrap modulo depth. Full/empty are distinguished with an extra pointer bit.

Test Plan:
- Reset, then one write (addr=2, wdata=0xA5) accepted at edge t -> mc_wr_en=1, mc_addr=2, mc_wdata=0xA5 for exactly one cycle after edge t+1; rsp_valid stays 0.
- Write addr=1 data=0x3C, then read addr=1, controller model with RD_LAT=1 -> mc_rd_en is one cycle after mc_wr_en; rsp_valid=1 with rsp_data=0x3C, captured at edge t+3 relative to read accept.
- Hold rsp_ready=0 and issue 6 reads (RSP_DEPTH=4) -> exactly 4 mc_rd_en pulses and req_ready drops once 4 commands are queued. Raise rsp_ready -> remaining 2 reads issue and 6 responses are returned in order.
- Stall with a read at the head (credits=0) and a write queued behind it -> the write does not issue until a response pop; mc_wr_en appears only after the blocked read's mc_rd_en.
- Fill the command FIFO (4 commands, with the issue path stalled by a credit-blocked read at the head) -> req_ready=0. A 5th req_valid is not accepted; after one pop, req_ready=1 on the next cycle.
- Assert reset with 2 reads in flight and 1 response queued -> immediately rsp_valid=0 and mc_*=0. After release, no response appears and credits are 4 (4 reads issue back-to-back).
